sram_fetch_rd: RTL and testbench

- Read initiator for the single-port, word-addressed, read-only instruction SRAM.
- Walks a byte PC and issues one SRAM read per cycle while it has credit.
- Tracks the SRAM's 1-cycle registered read latency and buffers responses in a small FIFO.
- Presents {instruction, PC} to the core front-end over a valid/ready handshake; supports redirect (flush) with discard of in-flight data.

---
 rtl/sram_fetch_rd.sv | 100 ++++++++++
 tb/tb_sram_fetch_rd.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fetch_rd.sv
// Instruction-SRAM read initiator: walks a byte PC, issues credit-limited reads,
// buffers 1-cycle-latency responses in a small FIFO and serves them over valid/ready.
module sram_fetch_rd #(
  parameter int          ADDR_W     = 15,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ren_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [31:0]       inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]       pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];

  logic              pop;
  logic              push;
  logic [CNT_W:0]    occupancy;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = data_mem_q[rd_ptr_q];
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];
  assign sram_addr_o  = pc_q[ADDR_W+1:2];

  assign pop  = inst_valid_o & inst_ready_i & ~flush_i;
  assign push = inflight_q & ~flush_i;

  // Credit counts the in-flight read as occupied so a response never lands in a full FIFO.
  assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign sram_ren_o = ~rst_i & ~flush_i & (occupancy < DEPTH_C);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = sram_ren_o;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (flush_i) begin
      pc_d     = flush_pc_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (sram_ren_o) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= sram_data_i;
        pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_fetch_rd.sv
// Directed + randomized bench for sram_fetch_rd against a queue-based fetch model.
module tb_sram_fetch_rd;
  localparam int          ADDR_W = 15;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [31:0]       flush_pc;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ren;
  logic [DATA_W-1:0] sram_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [31:0]       inst_pc;
  logic              ready;

  sram_fetch_rd #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flush_pc),
    .sram_addr_o(sram_addr), .sram_ren_o(sram_ren), .sram_data_i(sram_data),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM word k holds 0x1000 + k; registered read, drives 0 when not reading
  always @(posedge clk) sram_data <= sram_ren ? (32'h1000 + 32'(sram_addr)) : '0;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000 + {17'd0, pc[16:2]};
  endfunction

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] issue_pc;
  int          cyc;
  int          n_vec;
  int          n_err;
  int          n_ren;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: every read not yet delivered sits in q; its data is presentable 2 cycles after issue.
  task automatic sample();
    bit exp_valid, exp_pop, exp_ren;
    @(negedge clk);
    exp_valid = 1'b0;
    if (!rst && q.size() > 0) exp_valid = (cyc - q[0].cyc) >= 2;
    check("valid", inst_valid, exp_valid);
    if (exp_valid) begin
      check("head_pc", inst_pc, q[0].pc);
      check("head_inst", inst, word_of(q[0].pc));
    end
    exp_pop = exp_valid && ready && !flush;
    exp_ren = !rst && !flush && ((q.size() - int'(exp_pop)) < DEPTH);
    check("ren", sram_ren, exp_ren);
    if (exp_ren) check("addr", sram_addr, issue_pc[16:2]);
    n_ren += int'(sram_ren);
    if (rst) begin
      q.delete();
      issue_pc = RST_PC;
    end else if (flush) begin
      q.delete();
      issue_pc = flush_pc;
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_ren) begin
        q.push_back('{issue_pc, cyc});
        issue_pc = issue_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_ren = 0; cyc = 0;
    issue_pc = RST_PC;
    rst = 1'b1; flush = 1'b0; flush_pc = '0; ready = 1'b1;
    #2;
    check("rst_ren", sram_ren, 0);
    check("rst_addr", sram_addr, RST_PC[16:2]);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    step();
    step();

    // streaming from reset with ready held high
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (i == 0) begin
        check("s1_ren0", sram_ren, 1);
        check("s1_addr0", sram_addr, 0);
      end
      if (i == 1) check("s1_valid1", inst_valid, 0);
      if (i >= 2) begin
        check("s1_valid", inst_valid, 1);
        check("s1_pc", inst_pc, 32'((i - 2) * 4));
        check("s1_inst", inst, 32'h1000 + 32'(i - 2));
      end
      adv();
    end

    // stall from reset: only DEPTH reads go out
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b0; n_ren = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 5) begin
        check("s2_valid", inst_valid, 1);
        check("s2_head_inst", inst, 32'h1000);
        check("s2_head_pc", inst_pc, 0);
      end
      adv();
    end
    check("s2_reads", n_ren, 2);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("s2_drain_valid", inst_valid, 1);
      check("s2_drain_inst", inst, 32'h1000 + 32'(i));
      adv();
    end

    // flush with one entry stored and one read in flight
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b0;
    step();
    step();
    flush = 1'b1; flush_pc = 32'h40;
    sample();
    check("s3_ren_flush", sram_ren, 0);
    adv();
    flush = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 0) begin
        check("s3_ren", sram_ren, 1);
        check("s3_addr", sram_addr, 15'h10);
      end
      if (i < 2) check("s3_valid_low", inst_valid, 0);
      if (i == 2) begin
        check("s3_valid", inst_valid, 1);
        check("s3_pc", inst_pc, 32'h40);
        check("s3_inst", inst, 32'h1010);
      end
      adv();
    end

    // flush coinciding with valid & ready
    step();
    flush = 1'b1; flush_pc = 32'h80;
    sample();
    check("s4_valid_at_flush", inst_valid, 1);
    adv();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i < 2) check("s4_valid_low", inst_valid, 0);
      if (i == 2) begin
        check("s4_pc", inst_pc, 32'h80);
        check("s4_inst", inst, 32'h1020);
      end
      adv();
    end

    // ready toggling every cycle
    for (int i = 0; i < 20; i++) begin
      ready = (i % 2) == 0;
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // asynchronous reset between clock edges while streaming
    #3 rst = 1'b1;
    #1;
    check("s6_ren_async", sram_ren, 0);
    check("s6_valid_async", inst_valid, 0);
    check("s6_pc_async", inst_pc, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 0) check("s6_addr", sram_addr, RST_PC[16:2]);
      if (i == 1) check("s6_valid_low", inst_valid, 0);
      if (i == 2) begin
        check("s6_pc", inst_pc, RST_PC);
        check("s6_inst", inst, word_of(RST_PC));
      end
      adv();
    end

    // PC wrap past 0xFFFF_FFFC
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    step();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // randomized ready / flush traffic
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) flush_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else flush_pc = $urandom & 32'hFFFF_FFFC;
      step();
    end
    flush = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
